// File: rtl/sema_bank_if.sv
// sema_bank_if: bus bundle for the semaphore bank.
//
// Handshake: a request is valid while cs_i & cyc_i & stb_i are all high, and
// the master must hold adr_i/we_i/dat_i stable for as long as it stays valid.
// ack_o is the ready/done indication. The operation executes once on the
// first edge at which the slave samples a valid request. ack_o then stays high
// until the edge after the master drops the request. dat_o holds the result of
// the most recent read.
//
// Signals (slave view):
//   cs_i, cyc_i, stb_i  in   select qualifiers
//   we_i                in   write strobe
//   adr_i [AW-1:0]      in   {mode, index, amount}
//   dat_i [WID-1:0]     in   write data
//   ack_o               out  bus acknowledge
//   dat_o [WID-1:0]     out  registered read data
//   irq_o               out  OR of pending & enabled interrupt flags
//   busy_o              out  init sweep in progress
interface sema_bank_if #(
  parameter int AW  = 14,
  parameter int WID = 8
);
  logic           cs_i;
  logic           cyc_i;
  logic           stb_i;
  logic           we_i;
  logic [AW-1:0]  adr_i;
  logic [WID-1:0] dat_i;
  logic           ack_o;
  logic [WID-1:0] dat_o;
  logic           irq_o;
  logic           busy_o;

  modport master (
    output cs_i, cyc_i, stb_i, we_i, adr_i, dat_i,
    input  ack_o, dat_o, irq_o, busy_o
  );

  modport slave (
    input  cs_i, cyc_i, stb_i, we_i, adr_i, dat_i,
    output ack_o, dat_o, irq_o, busy_o
  );
endinterface

// File: rtl/sema_bank.sv
// sema_bank: bank of NSEM counting semaphores, each WID bits wide.
// The address selects the mode, the semaphore index and a small amount.
// Supported operations are saturating decrement/increment, try-acquire,
// interrupt enable, peek/poke, and reading/clearing the pending flag. A
// pending flag sets when a write moves a counter from zero to non-zero.
// After reset an init sweep loads every counter with RSTVAL.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_ni       in   synchronous active-low reset
//   bus          slave modport of sema_bank_if (bus, irq, busy)
//   dbg_state_o  out  current FSM state (0 INIT, 1 IDLE, 2 ACK)
module sema_bank #(
  parameter int NSEM     = 256,
  parameter int WID      = 8,
  parameter int AMT_BITS = 4,
  parameter int RSTVAL   = 0,
  localparam int SB      = $clog2(NSEM),
  localparam int AW      = 2 + SB + AMT_BITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  sema_bank_if.slave       bus,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam logic [WID-1:0] RST_W = WID'(RSTVAL);

  state_e          state_q, state_d;
  logic [SB-1:0]   idx_q, idx_d;
  logic            ack_q, ack_d;
  logic            busy_q, busy_d;
  logic            irq_q, irq_d;
  logic [WID-1:0]  dat_q, dat_d;
  logic [NSEM-1:0] ien_q, ien_d;
  logic [NSEM-1:0] pend_q, pend_d;

  // Counter storage: written once per cycle at most, read asynchronously.
  logic [WID-1:0]  cnt_q [NSEM];
  logic            mem_we;
  logic [SB-1:0]   mem_addr;
  logic [WID-1:0]  mem_wdata;

  // Address decode.
  logic                cs;
  logic [1:0]          mode;
  logic [SB-1:0]       n;
  logic [AMT_BITS-1:0] amt;
  logic [WID-1:0]      c;

  assign cs   = bus.cs_i & bus.cyc_i & bus.stb_i;
  assign mode = bus.adr_i[AW-1:AW-2];
  assign n    = bus.adr_i[AMT_BITS+SB-1:AMT_BITS];
  assign amt  = bus.adr_i[AMT_BITS-1:0];
  assign c    = cnt_q[n];

  // One extra bit of headroom: its value after add/subtract is the
  // carry/borrow that picks the saturation value.
  logic [WID:0]   amt_ext, sum, diff;
  logic [WID-1:0] sum_sat, dec_sat, try_val;

  assign amt_ext = (WID+1)'(amt);
  assign sum     = {1'b0, c} + amt_ext;
  assign diff    = {1'b0, c} - amt_ext;
  assign sum_sat = sum[WID]  ? {WID{1'b1}} : sum[WID-1:0];
  assign dec_sat = diff[WID] ? {WID{1'b0}} : diff[WID-1:0];
  assign try_val = diff[WID] ? c           : diff[WID-1:0];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
    dat_d     = dat_q;
    ien_d     = ien_q;
    pend_d    = pend_q;
    // irq follows pend/ien one edge after they change.
    irq_d     = |(pend_q & ien_q);
    mem_we    = 1'b0;
    mem_addr  = n;
    mem_wdata = c;

    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_addr  = idx_q;
        mem_wdata = RST_W;
        idx_d     = idx_q + SB'(1);
        if (idx_q == SB'(NSEM - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      ST_IDLE: begin
        if (cs) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          case ({mode, bus.we_i})
            3'b000: begin  // saturating decrement
              mem_we    = 1'b1;
              mem_wdata = dec_sat;
              dat_d     = c;
            end
            3'b001: begin  // saturating increment
              mem_we    = 1'b1;
              mem_wdata = sum_sat;
              if (c == '0 && sum_sat != '0) pend_d[n] = 1'b1;
            end
            3'b010: begin  // try-acquire: only subtract when it fits
              mem_we    = 1'b1;
              mem_wdata = try_val;
              dat_d     = c;
            end
            3'b011: ien_d[n] = bus.dat_i[0];
            3'b100: dat_d = c;  // peek
            3'b101: begin  // poke
              mem_we    = 1'b1;
              mem_wdata = bus.dat_i;
              if (c == '0 && bus.dat_i != '0) pend_d[n] = 1'b1;
            end
            3'b110: begin  // read-and-clear pending
              dat_d     = {{(WID-1){1'b0}}, pend_q[n]};
              pend_d[n] = 1'b0;
            end
            default: begin  // 3'b111: write-1-to-clear pending
              if (bus.dat_i[0]) pend_d[n] = 1'b0;
            end
          endcase
        end
      end

      ST_ACK: begin
        // Wait for the master to drop the request so it executes only once.
        if (!cs) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b1;
      irq_q   <= 1'b0;
      dat_q   <= '0;
      ien_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      irq_q   <= irq_d;
      dat_q   <= dat_d;
      ien_q   <= ien_d;
      pend_q  <= pend_d;
    end
  end

  // The counter array has no reset of its own; the sweep initialises it.
  // During reset, writes are blocked so that a transaction in flight is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_ni && mem_we) cnt_q[mem_addr] <= mem_wdata;
  end

  assign bus.ack_o   = ack_q;
  assign bus.dat_o   = dat_q;
  assign bus.irq_o   = irq_q;
  assign bus.busy_o  = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sema_bank.sv
// tb_sema_bank: self-checking bench for sema_bank at default parameters.
// A cycle-level behavioural model (plain arrays) predicts ack/dat/irq/busy.
// A compare process checks those predictions on every falling edge.
// Directed sequences add literal expectations; random traffic follows.
module tb_sema_bank;
  localparam int NSEM = 256;
  localparam int WID  = 8;
  localparam int AMTB = 4;
  localparam int AW   = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sema_bank_if #(.AW(AW), .WID(WID)) bus();
  logic [1:0] dbg_state;

  sema_bank #(.NSEM(NSEM), .WID(WID), .AMT_BITS(AMTB), .RSTVAL(0)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [WID-1:0] exp_q[$];

  // ---------------- behavioural model ----------------
  int       m_cnt [NSEM];
  bit       m_ien [NSEM];
  bit       m_pend[NSEM];
  int       m_init_left;
  bit       m_busy, m_ack, m_irq, m_valid;
  logic [WID-1:0] m_dat;
  int       mm_mode, mm_n, mm_a, mm_c, mm_nv, mm_d;
  bit       mm_cs, mm_irq_new;

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid     = 1'b1;
      m_busy      = 1'b1;
      m_init_left = NSEM;
      m_ack       = 1'b0;
      m_dat       = '0;
      m_irq       = 1'b0;
      for (int i = 0; i < NSEM; i++) begin
        m_ien[i]  = 1'b0;
        m_pend[i] = 1'b0;
      end
    end else if (m_valid) begin
      mm_irq_new = 1'b0;
      for (int i = 0; i < NSEM; i++) if (m_pend[i] && m_ien[i]) mm_irq_new = 1'b1;
      mm_cs = bus.cs_i & bus.cyc_i & bus.stb_i;
      if (m_init_left > 0) begin
        m_init_left--;
        if (m_init_left == 0) begin
          m_busy = 1'b0;
          for (int i = 0; i < NSEM; i++) m_cnt[i] = 0;
        end
      end else if (m_ack) begin
        if (!mm_cs) m_ack = 1'b0;
      end else if (mm_cs) begin
        m_ack   = 1'b1;
        mm_mode = int'(bus.adr_i[13:12]);
        mm_n    = int'(bus.adr_i[11:4]);
        mm_a    = int'(bus.adr_i[3:0]);
        mm_d    = int'(bus.dat_i);
        mm_c    = m_cnt[mm_n];
        case (mm_mode * 2 + int'(bus.we_i))
          0: begin
            m_cnt[mm_n] = (mm_c < mm_a) ? 0 : mm_c - mm_a;
            m_dat = WID'(mm_c); exp_q.push_back(WID'(mm_c));
          end
          1: begin
            mm_nv = (mm_c + mm_a > 255) ? 255 : mm_c + mm_a;
            if (mm_c == 0 && mm_nv != 0) m_pend[mm_n] = 1'b1;
            m_cnt[mm_n] = mm_nv;
          end
          2: begin
            if (mm_c >= mm_a) m_cnt[mm_n] = mm_c - mm_a;
            m_dat = WID'(mm_c); exp_q.push_back(WID'(mm_c));
          end
          3: m_ien[mm_n] = mm_d[0];
          4: begin m_dat = WID'(mm_c); exp_q.push_back(WID'(mm_c)); end
          5: begin
            if (mm_c == 0 && mm_d != 0) m_pend[mm_n] = 1'b1;
            m_cnt[mm_n] = mm_d;
          end
          6: begin
            m_dat = WID'(m_pend[mm_n]); exp_q.push_back(WID'(m_pend[mm_n]));
            m_pend[mm_n] = 1'b0;
          end
          default: if (mm_d[0]) m_pend[mm_n] = 1'b0;
        endcase
      end
      m_irq = mm_irq_new;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      vectors++;
      if (bus.ack_o !== m_ack || bus.busy_o !== m_busy ||
          bus.irq_o !== m_irq || bus.dat_o !== m_dat) begin
        miscompares++;
        $display("FAIL cycle t=%0t ack=%b/%b busy=%b/%b irq=%b/%b dat=%h/%h (dut/model)",
                 $time, bus.ack_o, m_ack, bus.busy_o, m_busy,
                 bus.irq_o, m_irq, bus.dat_o, m_dat);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one transaction, keep the request up for 'hold' acked edges, then drop it.
  task automatic op(input int mode, input int n, input int amt, input bit we,
                    input int data, input int hold,
                    output int rd, output int ack_cycles, output int wait_cycles);
    logic [WID-1:0] e;
    @(negedge clk);
    bus.cs_i  = 1'b1;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = we;
    bus.adr_i = {mode[1:0], n[7:0], amt[3:0]};
    bus.dat_i = data[7:0];
    wait_cycles = 0;
    do begin
      @(posedge clk); #1;
      wait_cycles++;
    end while (!bus.ack_o && wait_cycles < 2000);
    ack_cycles = 0;
    rd = int'(bus.dat_o);
    if (!bus.ack_o) begin
      check("ack_timeout", 0, 1);
    end else begin
      ack_cycles = 1;
      if (!we) begin
        if (exp_q.size() == 0) check("read_expected_missing", rd, -1);
        else begin
          e = exp_q.pop_front();
          check("read_data", rd, int'(e));
        end
      end
    end
    for (int k = 1; k < hold; k++) begin
      @(posedge clk); #1;
      if (bus.ack_o) ack_cycles++;
    end
    @(negedge clk);
    bus.cs_i = 1'b0;
    @(posedge clk); #1;
    if (bus.ack_o) ack_cycles++;
  endtask

  task automatic peek(input int n, output int v);
    int a, w;
    op(2, n, 0, 1'b0, 0, 1, v, a, w);
  endtask

  // ---------------- stimulus ----------------
  int rd, ac, wc, cycles, v;
  bit ack_seen;

  initial begin
    bus.cs_i = 1'b0; bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    bus.we_i = 1'b0; bus.adr_i = '0; bus.dat_i = '0;

    // Reset values.
    do_reset(3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_ack", int'(bus.ack_o), 0);
    check("rst_dat", int'(bus.dat_o), 0);
    check("rst_irq", int'(bus.irq_o), 0);
    check("rst_busy", int'(bus.busy_o), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Init sweep length, no ack while busy.
    cycles = 0; ack_seen = 1'b0;
    do begin
      @(posedge clk); #1;
      cycles++;
      if (bus.ack_o) ack_seen = 1'b1;
    end while (bus.busy_o && cycles < 2000);
    check("init_len", cycles, NSEM);
    check("init_no_ack", int'(ack_seen), 0);

    peek(0, v);   check("peek0", v, 0);
    peek(17, v);  check("peek17", v, 0);
    peek(255, v); check("peek255", v, 0);

    // Saturating decrement / increment.
    op(2, 5, 0, 1'b1, 8'h03, 1, rd, ac, wc);
    op(0, 5, 5, 1'b0, 0, 1, rd, ac, wc);  check("dec_dat", rd, 3);
    peek(5, v);                            check("dec_sat", v, 0);
    op(2, 5, 0, 1'b1, 8'hFD, 1, rd, ac, wc);
    op(0, 5, 4, 1'b1, 0, 1, rd, ac, wc);
    peek(5, v);                            check("inc_sat", v, 255);

    // Try-acquire.
    op(2, 9, 0, 1'b1, 2, 1, rd, ac, wc);
    op(1, 9, 3, 1'b0, 0, 1, rd, ac, wc);  check("try_fail_dat", rd, 2);
    peek(9, v);                            check("try_fail_cnt", v, 2);
    op(1, 9, 2, 1'b0, 0, 1, rd, ac, wc);  check("try_ok_dat", rd, 2);
    peek(9, v);                            check("try_ok_cnt", v, 0);
    op(1, 9, 0, 1'b0, 0, 1, rd, ac, wc);  check("try_amt0_dat", rd, 0);

    // Interrupt.
    op(1, 7, 0, 1'b1, 1, 1, rd, ac, wc);
    op(0, 7, 1, 1'b1, 0, 1, rd, ac, wc);  check("irq_set", int'(bus.irq_o), 1);
    op(3, 7, 0, 1'b0, 0, 1, rd, ac, wc);  check("pend_read", rd, 1);
    check("irq_clr", int'(bus.irq_o), 0);
    op(0, 7, 1, 1'b1, 0, 1, rd, ac, wc);
    @(posedge clk); #1;                    check("irq_no_retrig", int'(bus.irq_o), 0);

    // Held request executes once.
    op(2, 3, 0, 1'b1, 4, 1, rd, ac, wc);
    op(0, 3, 1, 1'b0, 0, 5, rd, ac, wc);  check("hold_ack_cycles", ac, 5);
    peek(3, v);                            check("hold_single", v, 3);

    // Reset mid-sweep, with a request pending across release.
    op(2, 200, 0, 1'b1, 8'h66, 1, rd, ac, wc);
    do_reset(2);
    repeat (100) @(posedge clk);
    do_reset(1);
    op(2, 200, 0, 1'b0, 0, 1, rd, ac, wc);
    check("pending_wait", wc, NSEM);
    check("pending_rd", rd, 0);

    // Random traffic on a small index window for collisions.
    for (int it = 0; it < 400; it++) begin
      int mode, n, amt, dat, hold, gap;
      bit we;
      mode = $urandom_range(0, 3);
      n    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      amt  = $urandom_range(0, 15);
      we   = 1'($urandom_range(0, 1));
      dat  = ($urandom_range(0, 1) == 1) ? $urandom_range(250, 255) : $urandom_range(0, 5);
      hold = $urandom_range(1, 3);
      gap  = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        bus.cs_i  = 1'($urandom_range(0, 1));
        bus.cyc_i = 1'($urandom_range(0, 1));
        bus.stb_i = 1'b0;
      end
      op(mode, n, amt, we, dat, hold, rd, ac, wc);
      if (ac != hold) check("rand_ack_cycles", ac, hold);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: bench did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sema_bank.md
# sema_bank

Parametrised counting-semaphore bank on the 8-bit bus, the next generation of the system semaphore memory. Each of `NSEM` counters is `WID` bits wide and supports saturating add/subtract, a non-destructive try-acquire, and peek/poke. A per-semaphore interrupt flags a 0→non-zero transition so waiters need not poll. After reset, a hardware init sweep loads every counter with `RSTVAL`.

## Interface
- `NSEM`, 256: number of semaphores (power of 2); `SB = $clog2(NSEM)`.
- `WID`, 8: counter and data width.
- `AMT_BITS`, 4: width of the amount field in the address.
- `RSTVAL`, 0: value written to every counter by the init sweep.
- `AW` (derived) = 2 + `SB` + `AMT_BITS` (14 at defaults).
- Address fields: `adr_i[AMT_BITS-1:0]` = amount `amt`; `adr_i[AMT_BITS+SB-1:AMT_BITS]` = index `n`; `adr_i[AW-1:AW-2]` = mode.

Ports:
- `clk_i` in 1: clock; all logic on rising edge.
- `rst_ni` in 1: reset; synchronous, active-low.
- `cs_i`, `cyc_i`, `stb_i` in 1 each: select qualifiers; `cs = cs_i & cyc_i & stb_i`.
- `we_i` in 1: write strobe.
- `adr_i` in `AW`: address.
- `dat_i` in `WID`: write data.
- `ack_o` out 1: bus acknowledge.
- `dat_o` out `WID`: read data (registered).
- `irq_o` out 1: OR over n of `pend[n] & ien[n]`.
- `busy_o` out 1: init sweep in progress.

## Operation
- Storage: count array `cnt[NSEM]` (RAM, async read); flop vectors `ien[NSEM]` and `pend[NSEM]`.
- FSM states: INIT, IDLE, ACK.
  - INIT: write `cnt[idx] <= RSTVAL`, `idx++`; go to IDLE after `idx == NSEM-1`. No ack is given and no operation executes.
  - IDLE: on `cs`, execute the operation once, then go to ACK.
  - ACK: `ack_o = 1`; return to IDLE when `cs` is 0.
- Each transaction executes exactly once, even if `cs` is held.
- Operations, with `c = cnt[n]` (old value); `dat_o <= c` on every read:
  - mode 00 read: `cnt[n] <= (c < amt) ? 0 : c - amt`.
  - mode 00 write: `cnt[n] <= min(c + amt, 2^WID-1)`.
  - mode 01 read (try-acquire): if `c >= amt`, `cnt[n] <= c - amt`; else unchanged. Software tests success as `dat_o >= amt`.
  - mode 01 write: `ien[n] <= dat_i[0]`.
  - mode 10 read: peek, no change.
  - mode 10 write: `cnt[n] <= dat_i`.
  - mode 11 read: `dat_o <= {WID-1'b0, pend[n]}` (this replaces the `dat_o <= c` rule); clears `pend[n]`.
  - mode 11 write: if `dat_i[0]`, clear `pend[n]`.
- Arithmetic is done in `WID+1` bits; the carry/borrow bit selects the saturation value.
- `amt` = 0 is legal: counter unchanged, and try-acquire always succeeds.
- `pend[n]` sets when an operation changes `cnt[n]` from 0 to non-zero (mode 00 write, mode 10 write). Set wins over clear only across different indices; the same transaction cannot both set and clear.
- `pend` and `ien` also update when `ien[n]` = 0. `irq_o` only masks.

## Timing
- Reset (`rst_ni` = 0 at an edge):
  - `ack_o` = 0, `dat_o` = 0, `irq_o` = 0, `busy_o` = 1.
  - `ien` and `pend` all 0; `idx` = 0; state = INIT.
- Reset asserted mid-sweep or mid-transaction restarts the sweep at index 0. A transaction in progress is dropped with no ack.
- Init takes `NSEM` cycles after `rst_ni` rises. `busy_o` falls on the edge that leaves INIT.
- Transaction latency:
  - `cs` sampled in IDLE at edge E: memory update and `dat_o` load at E.
  - `ack_o` is 1 from E until the edge after `cs` falls.
  - Minimum of one idle cycle between transactions, since a new one starts only in IDLE.
- A request raised during INIT stalls (no ack) and executes on the first IDLE cycle.
- `irq_o` is registered: it reflects `pend`/`ien` one cycle after the update edge.
- `dat_o` holds its value between reads; writes leave `dat_o` unchanged.

## Test plan
- Reset, release `rst_ni` → `busy_o` = 1 for exactly 256 cycles, no `ack_o` during that time; then peek (mode 10 read) of n=0, 17, 255 returns 0.
- Poke n=5 := 0x03 (mode 10 write) then decrement n=5 by 5 (mode 00 read) → `dat_o` = 0x03, peek = 0x00. Poke 0xFD, increment by 4 → peek = 0xFF.
- Try-acquire n=9 with `cnt` = 2, amt = 3 → `dat_o` = 2, count stays 2. Repeat with amt = 2 → `dat_o` = 2, count = 0.
- Enable irq n=7 (mode 01 write, `dat_i` = 1), increment n=7 by 1 from 0 → `irq_o` = 1. Mode 11 read → `dat_o` = 0x01, then `irq_o` = 0. Increment n=7 again (1→2) → `irq_o` stays 0.
- Hold `cs` for 5 cycles on decrement n=3 by 1 from 4 → count = 3 (single execution), `ack_o` high cycles 2–6 then low.
- Assert `rst_ni` = 0 at sweep index 100, release → full 256-cycle sweep. A request pending at release is acked only after `busy_o` falls.
